// File: rtl/frame_pattern_sequencer.sv
// frame_pattern_sequencer
//   Chooses which test pattern the paint mux draws. Steps to the next pattern
//   every HOLD_FRAMES frames, or on a debounced btn_next press; btn_pause
//   toggles auto-advance on and off. A new pattern only takes effect at the
//   start of vertical blanking, so a visible frame never mixes two patterns.
//
// Ports
//   clk_pix       pixel clock
//   rst_pix_n     synchronous active-low reset
//   sx, sy        screen position from the display timing generator
//   btn_next      raw advance button (asynchronous, active-high)
//   btn_pause     raw pause-toggle button (asynchronous, active-high)
//   pattern       selected pattern index
//   pattern_valid high once the first vblank after reset has been seen
//   switched      one-cycle pulse alongside each new pattern value
//   paused        auto-advance suspended
//   frame_cnt     frames shown of the current pattern
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | waiting for the first vblank; pattern not yet valid
// RUN   | normal operation, no advance request outstanding
// ARMED | next press captured, advance at the coming vblank
module frame_pattern_sequencer #(
  parameter int CORDW       = 12,
  parameter int V_RES       = 720,
  parameter int PATTERNS    = 4,
  parameter int HOLD_FRAMES = 120,
  parameter int DEBOUNCE    = 16,
  localparam int PW = $clog2(PATTERNS),
  localparam int FW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             btn_next,
  input  logic             btn_pause,
  output logic [PW-1:0]    pattern,
  output logic             pattern_valid,
  output logic             switched,
  output logic             paused,
  output logic [FW-1:0]    frame_cnt
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]    CNT_INIT  = CW'(DEBOUNCE - 1);
  localparam logic [CORDW-1:0] V_LINE    = CORDW'(V_RES);
  localparam logic [PW-1:0]    PAT_LAST  = PW'(PATTERNS - 1);
  localparam logic [FW-1:0]    HOLD_LAST = (HOLD_FRAMES > 0) ? FW'(HOLD_FRAMES - 1) : '0;
  localparam logic             HOLD_EN   = (HOLD_FRAMES != 0);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_ARMED} state_t;

  // ---------------- button conditioning (bit 0 = next, bit 1 = pause) -----
  logic [1:0]    btn_raw;
  logic [1:0]    sync1, sync2;
  logic [1:0]    db_lvl;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  assign btn_raw = {btn_pause, btn_next};

  // Down-counter reloads whenever the synchronised level agrees with the
  // accepted level, so any glitch restarts the stability window.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= CNT_INIT;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= CNT_INIT;
        end else if (db_cnt[i] == '0) begin
          db_cnt[i] <= CNT_INIT;
          db_lvl[i] <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] - CW'(1);
        end
      end
    end
  end

  logic next_press, pause_press;
  assign next_press  = press[0];
  assign pause_press = press[1];

  // ---------------- sequencing FSM ----------------------------------------
  state_t        state, state_n;
  logic [PW-1:0] pattern_n;
  logic          valid_n, switched_n, paused_n, pending, pending_n;
  logic [FW-1:0] frame_cnt_n;
  logic          vb, expire, adv;
  logic [PW-1:0] pat_inc;

  assign vb      = (sy == V_LINE) && (sx == '0);
  // Uses the registered paused value, so a pause press landing on vb does
  // not affect expiry at that same vb.
  assign expire  = HOLD_EN && !paused && (frame_cnt == HOLD_LAST);
  assign adv     = pending || next_press || expire;
  assign pat_inc = (pattern == PAT_LAST) ? '0 : pattern + PW'(1);

  always_comb begin
    state_n     = state;
    pattern_n   = pattern;
    valid_n     = pattern_valid;
    switched_n  = 1'b0;
    paused_n    = paused ^ pause_press;
    frame_cnt_n = frame_cnt;
    pending_n   = pending;
    case (state)
      S_INIT: begin
        if (vb) begin
          state_n     = S_RUN;
          valid_n     = 1'b1;
          frame_cnt_n = '0;
        end
      end
      S_RUN: begin
        if (vb) begin
          if (adv) begin
            pattern_n   = pat_inc;
            frame_cnt_n = '0;
            switched_n  = 1'b1;
          end else if (HOLD_EN && !paused) begin
            frame_cnt_n = frame_cnt + FW'(1);
          end
        end else if (next_press) begin
          pending_n = 1'b1;
          state_n   = S_ARMED;
        end
      end
      S_ARMED: begin
        // Extra presses while armed coalesce: at most one advance per vblank.
        if (vb) begin
          pattern_n   = pat_inc;
          frame_cnt_n = '0;
          switched_n  = 1'b1;
          pending_n   = 1'b0;
          state_n     = S_RUN;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state         <= S_INIT;
      pattern       <= '0;
      pattern_valid <= 1'b0;
      switched      <= 1'b0;
      paused        <= 1'b0;
      frame_cnt     <= '0;
      pending       <= 1'b0;
    end else begin
      state         <= state_n;
      pattern       <= pattern_n;
      pattern_valid <= valid_n;
      switched      <= switched_n;
      paused        <= paused_n;
      frame_cnt     <= frame_cnt_n;
      pending       <= pending_n;
    end
  end

endmodule
